// File: rtl/rsa_operand_loader.sv
// Operand entry and launch control for the RSA core: byte-wise M/E/N entry,
// a single go/done encryption run with modulus and timeout guards, and result capture.
module rsa_operand_loader #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      sw_data,
  input  logic [1:0]      sel,
  input  logic            load,
  input  logic            clear,
  input  logic            start,
  output logic [BITS-1:0] m,
  output logic [BITS-1:0] e,
  output logic [BITS-1:0] n,
  output logic            go,
  input  logic [BITS-1:0] r,
  input  logic            d,
  output logic [BITS-1:0] result,
  output logic [15:0]     display,
  output logic            result_valid,
  output logic            busy,
  output logic            error
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = (BITS < 16) ? BITS : 16;
  localparam logic [BITS-1:0] N_MIN   = BITS'(2);
  localparam logic [CW-1:0]   CNT_END = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] m_q, m_d;
  logic [BITS-1:0] e_q, e_d;
  logic [BITS-1:0] n_q, n_d;
  logic [BITS-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;
  logic            error_q, error_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      m_q            <= '0;
      e_q            <= '0;
      n_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      e_q            <= e_d;
      n_q            <= n_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    e_d            = e_q;
    n_d            = n_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          m_d            = '0;
          e_d            = '0;
          n_d            = '0;
          result_valid_d = 1'b0;
          error_d        = 1'b0;
        end else if (load) begin
          // Shift instead of slicing so BITS=8 elaborates cleanly.
          unique case (sel)
            2'b00:   m_d = (m_q << 8) | BITS'(sw_data);
            2'b01:   e_d = (e_q << 8) | BITS'(sw_data);
            2'b10:   n_d = (n_q << 8) | BITS'(sw_data);
            default: ;
          endcase
        end
        // Modulus check looks at the register as it stood before any same-cycle load.
        if (start) begin
          if (n_q < N_MIN) begin
            error_d = 1'b1;
          end else begin
            result_valid_d = 1'b0;
            cnt_d          = '0;
            state_d        = S_RUN;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        if (d) begin
          result_d = r;
          state_d  = S_CAPTURE;
        end else if (cnt_inc == CNT_END) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_CAPTURE: begin
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign m            = m_q;
  assign e            = e_q;
  assign n            = n_q;
  assign go           = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign display      = 16'(result_q[DW-1:0]);

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader with a hand-driven core stub (TIMEOUT=50).
module tb_rsa_operand_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  sw_data;
  logic [1:0]  sel;
  logic        load, clear, start;
  logic [31:0] m, e, n, r, result;
  logic        go, d, result_valid, busy, error;
  logic [15:0] display;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  rsa_operand_loader #(.BITS(32), .TIMEOUT(50)) dut (
    .clk(clk), .reset_n(reset_n), .sw_data(sw_data), .sel(sel), .load(load),
    .clear(clear), .start(start), .m(m), .e(e), .n(n), .go(go), .r(r), .d(d),
    .result(result), .display(display), .result_valid(result_valid),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [1:0] s, input logic [7:0] b);
    sel = s; sw_data = b; load = 1'b1;
    tick();
    load = 1'b0; sel = 2'b11;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic load_std_operands();
    load_byte(2'b10, 8'h00); load_byte(2'b10, 8'h00);
    load_byte(2'b10, 8'h04); load_byte(2'b10, 8'hA5);
    load_byte(2'b00, 8'h00); load_byte(2'b00, 8'h00);
    load_byte(2'b00, 8'h00); load_byte(2'b00, 8'hBE);
    load_byte(2'b01, 8'h03);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++; if ({m, e, n, result} !== 128'h0) $display("FAIL reset_regs: got m=%h e=%h n=%h result=%h, expected all 0", m, e, n, result); else n_pass++;
    n_checks++; if ({go, busy, error, result_valid} !== 4'b0000) $display("FAIL reset_flags: got go/busy/error/rv=%b, expected 0000", {go, busy, error, result_valid}); else n_pass++;
    n_checks++; if (display !== 16'h0000) $display("FAIL reset_display: got %h, expected 0000", display); else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (go !== 1'b0) $display("FAIL idle_go cycle %0d: got %b, expected 0", i, go); else n_pass++;
    end
  endtask

  task automatic test_load_run();
    load_std_operands();
    n_checks++; if (n !== 32'h0000_04A5) $display("FAIL load_n: got %h, expected 000004a5", n); else n_pass++;
    n_checks++; if (m !== 32'h0000_00BE) $display("FAIL load_m: got %h, expected 000000be", m); else n_pass++;
    n_checks++; if (e !== 32'h0000_0003) $display("FAIL load_e: got %h, expected 00000003", e); else n_pass++;
    pulse_start();
    n_checks++; if ({go, busy} !== 2'b11) $display("FAIL run_go_latency: got go/busy=%b, expected 11", {go, busy}); else n_pass++;
    for (int i = 0; i < 19; i++) begin
      tick();
      n_checks++; if (go !== 1'b1) $display("FAIL run_go_hold cycle %0d: got %b, expected 1", i, go); else n_pass++;
    end
    d = 1'b1; r = 32'd848;
    tick();
    d = 1'b0;
    n_checks++; if (result !== 32'd848) $display("FAIL run_result: got %0d, expected 848", result); else n_pass++;
    n_checks++; if (display !== 16'h0350) $display("FAIL run_display: got %h, expected 0350", display); else n_pass++;
    n_checks++; if ({go, busy, result_valid} !== 3'b010) $display("FAIL run_capture_flags: got go/busy/rv=%b, expected 010", {go, busy, result_valid}); else n_pass++;
    tick();
    n_checks++; if ({result_valid, busy, go} !== 3'b100) $display("FAIL run_result_valid: got rv/busy/go=%b, expected 100", {result_valid, busy, go}); else n_pass++;
  endtask

  task automatic test_bad_modulus();
    pulse_clear();
    n_checks++; if ({m, e, n} !== 96'h0 || result_valid !== 1'b0) $display("FAIL clear_regs: got m=%h e=%h n=%h rv=%b, expected zeros", m, e, n, result_valid); else n_pass++;
    load_byte(2'b10, 8'h01);
    pulse_start();
    n_checks++; if ({error, go, busy} !== 3'b100) $display("FAIL badmod_error: got error/go/busy=%b, expected 100", {error, go, busy}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (go !== 1'b0) $display("FAIL badmod_go cycle %0d: got %b, expected 0", i, go); else n_pass++;
    end
    pulse_clear();
    n_checks++; if (error !== 1'b0) $display("FAIL badmod_clear: got error=%b, expected 0", error); else n_pass++;
  endtask

  task automatic test_start_with_load();
    // n is 0: a same-cycle load of 05 must not rescue the start.
    sel = 2'b10; sw_data = 8'h05; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0; sel = 2'b11;
    n_checks++; if ({error, go} !== 2'b10) $display("FAIL startload_error: got error/go=%b, expected 10", {error, go}); else n_pass++;
    n_checks++; if (n !== 32'h5) $display("FAIL startload_n: got %h, expected 00000005", n); else n_pass++;
    // error stays sticky while a valid start still launches
    pulse_start();
    n_checks++; if ({error, go} !== 2'b11) $display("FAIL sticky_run: got error/go=%b, expected 11", {error, go}); else n_pass++;
    d = 1'b1; r = 32'hCAFE_0001;
    tick();
    d = 1'b0;
    tick();
    n_checks++; if (result !== 32'hCAFE_0001 || result_valid !== 1'b1 || error !== 1'b1) $display("FAIL sticky_result: got result=%h rv=%b err=%b, expected cafe0001 1 1", result, result_valid, error); else n_pass++;
    pulse_clear();
  endtask

  task automatic test_timeout();
    int unsigned go_cycles;
    load_byte(2'b10, 8'h04); load_byte(2'b10, 8'hA5);
    pulse_start();
    go_cycles = 0;
    while (go === 1'b1 && go_cycles < 200) begin
      go_cycles++;
      tick();
    end
    n_checks++; if (go_cycles !== 50) $display("FAIL timeout_go_cycles: got %0d, expected 50", go_cycles); else n_pass++;
    n_checks++; if ({error, busy, result_valid} !== 3'b100) $display("FAIL timeout_flags: got err/busy/rv=%b, expected 100", {error, busy, result_valid}); else n_pass++;
    n_checks++; if (result !== 32'hCAFE_0001) $display("FAIL timeout_result: got %h, expected cafe0001", result); else n_pass++;
    pulse_clear();
  endtask

  task automatic test_interference();
    load_std_operands();
    pulse_start();
    n_checks++; if (go !== 1'b1) $display("FAIL intf_go: got %b, expected 1", go); else n_pass++;
    load_byte(2'b00, 8'hFF);
    pulse_clear();
    pulse_start();
    n_checks++; if (m !== 32'hBE || e !== 32'h3 || n !== 32'h4A5) $display("FAIL intf_regs: got m=%h e=%h n=%h, expected be 3 4a5", m, e, n); else n_pass++;
    n_checks++; if (go !== 1'b1) $display("FAIL intf_go_hold: got %b, expected 1", go); else n_pass++;
    d = 1'b1; r = 32'h1234_5678;
    tick();
    d = 1'b0;
    n_checks++; if (result !== 32'h1234_5678 || display !== 16'h5678 || go !== 1'b0) $display("FAIL intf_result: got result=%h display=%h go=%b, expected 12345678 5678 0", result, display, go); else n_pass++;
    tick();
    n_checks++; if (result_valid !== 1'b1) $display("FAIL intf_valid: got %b, expected 1", result_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    repeat (4) tick();
    n_checks++; if (go !== 1'b1) $display("FAIL midrst_pre_go: got %b, expected 1", go); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({go, busy, result_valid} !== 3'b000) $display("FAIL midrst_flags: got go/busy/rv=%b, expected 000", {go, busy, result_valid}); else n_pass++;
    n_checks++; if (result !== 32'h0 || n !== 32'h0) $display("FAIL midrst_regs: got result=%h n=%h, expected 0 0", result, n); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    load_std_operands();
    pulse_start();
    n_checks++; if (go !== 1'b1) $display("FAIL midrst_restart_go: got %b, expected 1", go); else n_pass++;
    repeat (2) tick();
    d = 1'b1; r = 32'd848;
    tick();
    d = 1'b0;
    tick();
    n_checks++; if (result !== 32'd848 || result_valid !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_result: got result=%0d rv=%b busy=%b, expected 848 1 0", result, result_valid, busy); else n_pass++;
  endtask

  initial begin
    sw_data = '0; sel = 2'b11; load = 0; clear = 0; start = 0; d = 0; r = '0;
    reset_n = 1'b0;
    test_reset();
    test_load_run();
    test_bad_modulus();
    test_start_with_load();
    test_timeout();
    test_interference();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_operand_loader.md
Name: rsa_operand_loader

Overview:
- Front-end control stage sitting directly upstream of the RSA encryption core (ports clk, go, m, e, n, r, d).
- Assembles the message, exponent and modulus from byte-wide switch entry, then runs one encryption via the core's level-sensitive go / done handshake.
- Captures the core's result and presents it for display.
- Guards against a zero or one modulus and against a core that never completes.

Parameters:
- BITS, 32, operand and result width; must be a multiple of 8, minimum 8.
- TIMEOUT, 65535, maximum clk cycles in RUN waiting for d before the block aborts; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sw_data  in  8  byte from the debounced switches.
- sel  in  2  target register: 00=M, 01=E, 10=N, 11=none (load ignored).
- load  in  1  single-cycle pulse; shifts sw_data into the selected register.
- clear  in  1  single-cycle pulse; zeroes M/E/N and clears result_valid and error.
- start  in  1  single-cycle pulse; launches an encryption.
- m  out  BITS  message to the core.
- e  out  BITS  exponent to the core.
- n  out  BITS  modulus to the core.
- go  out  1  core enable; held high for the whole RUN state.
- r  in  BITS  result from the core.
- d  in  1  core done; level, valid while go is high.
- result  out  BITS  captured result.
- display  out  16  result[15:0].
- result_valid  out  1  high from capture until clear, the next start, or reset.
- busy  out  1  high in RUN and CAPTURE.
- error  out  1  sticky; set on bad modulus or timeout.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. m, e, n, result = 0. go, result_valid, busy, error = 0. Timeout counter = 0.
- States: IDLE, RUN, CAPTURE.
- IDLE
  - load with sel!=11: selected reg <= {reg[BITS-9:0], sw_data}, so the MSB byte is entered first and older bytes shift out the top. sel=11: no change.
  - clear: m, e, n = 0; result_valid = 0; error = 0. clear beats load in the same cycle.
  - start with n<2: error=1, stay in IDLE, go stays 0.
  - start with n>=2: result_valid=0, counter=0, go=1 next cycle, state=RUN.
  - start and load in the same cycle: the load is applied first. The n<2 check and the launch use the pre-load register values; the updated value reaches the m/e/n outputs one cycle later.
- RUN
  - go=1, busy=1. m/e/n frozen; load and clear are ignored; start is ignored.
  - Counter increments each cycle.
  - d=1: result <= r, go <= 0, state=CAPTURE.
  - Counter reaches TIMEOUT with d=0: go <= 0, error <= 1, result unchanged, state=IDLE.
  - d and timeout in the same cycle: d wins and the result is captured.
- CAPTURE: one cycle with go=0, giving the core its deassertion cycle. result_valid <= 1, busy deasserts, state=IDLE.
- Latency: start to go=1 is 1 cycle. d=1 to result/go=0 is 1 cycle. d=1 to result_valid=1 is 2 cycles.
- Error is sticky: only clear or reset removes it. A later start with n>=2 still runs while error remains set.
- display is combinational from result[15:0].
- reset_n low mid-RUN drops go asynchronously; no partial result is captured.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles -> all outputs 0, state IDLE; release and hold 10 cycles -> go stays 0.
- Load and run:
  - Stimulus: sel=10 with bytes 00,00,04,A5; sel=00 with bytes 00,00,00,BE; sel=01 with byte 03; then start.
  - Core stub returns r=848 (190^3 mod 1189) with d high after 20 cycles.
  - Required response: n=0x4A5, m=0xBE, e=3; go high 1 cycle after start; result=848 and display=0x0350; go low 1 cycle after d; result_valid 2 cycles after d.
- Bad modulus: clear, load N=0x01, start -> error=1, go never asserts; clear -> error=0.
- Timeout: set TIMEOUT=50, stub never raises d, start -> go high for exactly 50 cycles, then error=1, result unchanged, state IDLE.
- Interference during RUN: pulse load (sel=00, sw_data=FF), clear and start while go=1 -> m/e/n unchanged and the run completes normally.
- Reset mid-run: drop reset_n 5 cycles into RUN -> go=0 immediately, result=0, result_valid=0; a fresh load and start afterwards completes correctly.
